// File: rtl/knn_seq_pkg.sv
// Shared definitions for the k-NN sequencer: core command codes, FSM states
// and the bit positions of the {x, y, label} fields in a memory word.
package knn_seq_pkg;

  typedef enum logic [2:0] {
    CTRL_HOLD        = 3'b000,
    CTRL_LOAD_TEST   = 3'b001,
    CTRL_INSERT_DATA = 3'b010,
    CTRL_CLASSIFY    = 3'b100
  } core_ctrl_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_FETCH_T,
    S_LOAD_T,
    S_FETCH_D,
    S_PUSH_D,
    S_VOTE,
    S_WRITE,
    S_FIN
  } state_e;

  localparam int LABEL_LSB = 0;

  function automatic int y_lsb(input int label_w);
    return label_w;
  endfunction

  function automatic int x_lsb(input int coord_w, input int label_w);
    return label_w + coord_w;
  endfunction

endpackage

// File: rtl/knn_seq_fetch.sv
// Request/acknowledge read engine shared by the test-point and data-point
// fetches; keeps one capture register per target.
module knn_seq_fetch
  import knn_seq_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int LABEL_W = 8,
  parameter int ADDR_W  = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         tgt_data,
  input  logic                         abort,
  input  logic [ADDR_W-1:0]            addr,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  input  logic [2*COORD_W+LABEL_W-1:0] mem_rdata,
  output logic                         fire,
  output logic [2*COORD_W-1:0]         tpt_q,
  output logic [2*COORD_W+LABEL_W-1:0] dpt_q
);

  localparam int DATA_W = 2*COORD_W + LABEL_W;
  localparam int YL     = y_lsb(LABEL_W);

  logic [2*COORD_W-1:0] tpt_d;
  logic [DATA_W-1:0]    dpt_d;

  // An abort in the same cycle as the acknowledge discards the read.
  assign fire     = en & mem_ack & ~abort;
  assign mem_req  = en;
  assign mem_addr = en ? addr : '0;

  always_comb begin
    tpt_d = tpt_q;
    dpt_d = dpt_q;
    if (fire && !tgt_data) tpt_d = mem_rdata[DATA_W-1:YL];
    if (fire && tgt_data)  dpt_d = mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tpt_q <= '0;
      dpt_q <= '0;
    end else begin
      tpt_q <= tpt_d;
      dpt_q <= dpt_d;
    end
  end

endmodule

// File: rtl/knn_seq.sv
// k-NN run sequencer: streams each test point and then every dataset point
// into the classification core, and writes one label per test point.
module knn_seq
  import knn_seq_pkg::*;
#(
  parameter int COORD_W  = 16,
  parameter int LABEL_W  = 8,
  parameter int ADDR_W   = 10,
  parameter int NK_W     = 4,
  parameter int VOTE_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NK_W-1:0]              nk,
  input  logic [ADDR_W-1:0]            n_data,
  input  logic [ADDR_W-1:0]            n_test,
  input  logic [ADDR_W-1:0]            test_base,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  input  logic [2*COORD_W+LABEL_W-1:0] mem_rdata,
  output logic                         core_rst,
  output logic [2:0]                   core_ctrl,
  output logic [NK_W-1:0]              core_nk,
  output logic [COORD_W-1:0]           core_x,
  output logic [COORD_W-1:0]           core_y,
  output logic [COORD_W-1:0]           core_dx,
  output logic [COORD_W-1:0]           core_dy,
  output logic [LABEL_W-1:0]           core_dlabel,
  input  logic [LABEL_W-1:0]           core_label,
  output logic                         res_valid,
  output logic [ADDR_W-1:0]            res_addr,
  output logic [LABEL_W-1:0]           res_label
);

  localparam int DATA_W = 2*COORD_W + LABEL_W;
  localparam int XL     = x_lsb(COORD_W, LABEL_W);
  localparam int YL     = y_lsb(LABEL_W);

  state_e              state_q, state_d;
  logic [NK_W-1:0]     nk_q, nk_d;
  logic [ADDR_W-1:0]   n_data_q, n_data_d, n_test_q, n_test_d;
  logic [ADDR_W-1:0]   test_base_q, test_base_d, t_q, t_d, d_q, d_d;
  logic [7:0]          vcnt_q, vcnt_d;
  logic                abort_q, abort_d;
  logic [ADDR_W:0]     t_inc, d_inc;
  logic                fetch_en, fetch_data, fire;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [2*COORD_W-1:0] tpt;
  logic [DATA_W-1:0]   dpt;

  assign fetch_en   = (state_q == S_FETCH_T) || (state_q == S_FETCH_D);
  assign fetch_data = (state_q == S_FETCH_D);
  assign fetch_addr = fetch_data ? d_q : test_base_q + t_q;
  assign t_inc      = {1'b0, t_q} + 1'b1;
  assign d_inc      = {1'b0, d_q} + 1'b1;

  knn_seq_fetch #(
    .COORD_W(COORD_W),
    .LABEL_W(LABEL_W),
    .ADDR_W (ADDR_W)
  ) u_fetch (
    .clk      (clk),
    .rst      (rst),
    .en       (fetch_en),
    .tgt_data (fetch_data),
    .abort    (abort),
    .addr     (fetch_addr),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .fire     (fire),
    .tpt_q    (tpt),
    .dpt_q    (dpt)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    nk_d        = nk_q;
    n_data_d    = n_data_q;
    n_test_d    = n_test_q;
    test_base_d = test_base_q;
    t_d         = t_q;
    d_d         = d_q;
    vcnt_d      = '0;
    busy        = (state_q != S_IDLE);
    abort_d     = busy & abort;
    core_ctrl   = CTRL_HOLD;
    core_rst    = abort_q;
    res_valid   = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: if (start) begin
        nk_d        = nk;
        n_data_d    = n_data;
        n_test_d    = n_test;
        test_base_d = test_base;
        state_d     = S_CLR;
      end
      S_CLR: begin
        core_rst = 1'b1;
        t_d      = '0;
        d_d      = '0;
        state_d  = (n_test_q == '0) ? S_FIN : S_FETCH_T;
      end
      S_FETCH_T: if (fire) state_d = S_LOAD_T;
      S_LOAD_T: begin
        core_ctrl = CTRL_LOAD_TEST;
        state_d   = (n_data_q == '0) ? S_VOTE : S_FETCH_D;
      end
      S_FETCH_D: if (fire) state_d = S_PUSH_D;
      S_PUSH_D: begin
        core_ctrl = CTRL_INSERT_DATA;
        d_d       = d_inc[ADDR_W-1:0];
        state_d   = (d_inc < {1'b0, n_data_q}) ? S_FETCH_D : S_VOTE;
      end
      // CLASSIFY is issued on the first VOTE cycle; WRITE lands VOTE_LAT cycles later.
      S_VOTE: begin
        if (vcnt_q == '0) core_ctrl = CTRL_CLASSIFY;
        vcnt_d = vcnt_q + 8'd1;
        if (int'(vcnt_q) >= VOTE_LAT - 1) state_d = S_WRITE;
      end
      S_WRITE: begin
        res_valid = 1'b1;
        core_rst  = 1'b1;
        d_d       = '0;
        t_d       = t_inc[ADDR_W-1:0];
        state_d   = (t_inc < {1'b0, n_test_q}) ? S_FETCH_T : S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_d) begin
      state_d   = S_IDLE;
      core_ctrl = CTRL_HOLD;
      res_valid = 1'b0;
      done      = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      nk_q        <= '0;
      n_data_q    <= '0;
      n_test_q    <= '0;
      test_base_q <= '0;
      t_q         <= '0;
      d_q         <= '0;
      vcnt_q      <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      nk_q        <= nk_d;
      n_data_q    <= n_data_d;
      n_test_q    <= n_test_d;
      test_base_q <= test_base_d;
      t_q         <= t_d;
      d_q         <= d_d;
      vcnt_q      <= vcnt_d;
      abort_q     <= abort_d;
    end
  end

  assign core_nk     = nk_q;
  assign core_x      = tpt[COORD_W +: COORD_W];
  assign core_y      = tpt[0 +: COORD_W];
  assign core_dx     = dpt[XL +: COORD_W];
  assign core_dy     = dpt[YL +: COORD_W];
  assign core_dlabel = dpt[LABEL_LSB +: LABEL_W];
  assign res_addr    = t_q;
  assign res_label   = (state_q == S_WRITE) ? core_label : '0;

endmodule
